// File: rtl/logic_circuit.sv
// Registered one-bit carry/sum cell for carry-lookahead slices.
// Carry-out uses the externally supplied generate/propagate terms as-is; a separate
// flag reports when those terms disagree with the operand bits. A saturating counter
// tracks how many samples produced a carry-out.
module logic_circuit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             G,
  input  logic             P,
  output logic             X,
  output logic             Y,
  output logic             valid,
  output logic             pg_err,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             x_n;
  logic             y_n;
  logic             err_n;
  logic             cnt_inc;

  logic             x_q;
  logic             y_q;
  logic             valid_q;
  logic             pg_err_q;
  logic [CNT_W-1:0] carry_cnt_q;
  logic [CNT_W-1:0] carry_cnt_d;

  // Next-state terms; G/P are trusted for X even when inconsistent with A/B.
  always_comb begin
    x_n         = G | (P & C);
    y_n         = A ^ B ^ C;
    err_n       = (G != (A & B)) | (P != (A | B));
    cnt_inc     = en & x_n & (carry_cnt_q != CntMax);
    carry_cnt_d = carry_cnt_q;
    if (cnt_inc) begin
      carry_cnt_d = carry_cnt_q + 1'b1;
    end
  end

  // Output registers: capture on enable, hold otherwise; valid pulses one cycle per sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      valid_q     <= 1'b0;
      pg_err_q    <= 1'b0;
      carry_cnt_q <= '0;
    end else begin
      valid_q     <= en;
      carry_cnt_q <= carry_cnt_d;
      if (en) begin
        x_q      <= x_n;
        y_q      <= y_n;
        pg_err_q <= err_n;
      end
    end
  end

  assign X         = x_q;
  assign Y         = y_q;
  assign valid     = valid_q;
  assign pg_err    = pg_err_q;
  assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_logic_circuit.sv
// Self-checking bench for logic_circuit: a behavioural reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_logic_circuit;

  localparam int unsigned CntW   = 8;
  localparam int unsigned CntSat = (1 << CntW) - 1;

  logic            clk;
  logic            rst;
  logic            en;
  logic            A, B, C, G, P;
  logic            X, Y, valid, pg_err;
  logic [CntW-1:0] carry_cnt;

  int errors;
  int checks;
  bit chk_on;

  // Reference model state
  bit          m_x, m_y, m_valid, m_err;
  int unsigned m_cnt;

  logic_circuit #(.CNT_W(CntW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .A         (A),
    .B         (B),
    .C         (C),
    .G         (G),
    .P         (P),
    .X         (X),
    .Y         (Y),
    .valid     (valid),
    .pg_err    (pg_err),
    .carry_cnt (carry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model from the behavioural rules: sum is operand parity, G/P should match AND/OR.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x     <= 1'b0;
      m_y     <= 1'b0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_cnt   <= 0;
    end else if (en) begin
      m_x     <= G || (P && C);
      m_y     <= ((int'(A) + int'(B) + int'(C)) % 2) == 1;
      m_err   <= (G != ((int'(A) + int'(B)) == 2)) || (P != ((int'(A) + int'(B)) >= 1));
      m_valid <= 1'b1;
      if ((G || (P && C)) && m_cnt < CntSat) m_cnt <= m_cnt + 1;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_X", X, m_x);
      check("m_Y", Y, m_y);
      check("m_valid", valid, m_valid);
      check("m_pg_err", pg_err, m_err);
      check("m_carry_cnt", carry_cnt, m_cnt);
    end
  end

  task automatic drive(input bit e, input bit a, input bit b, input bit c, input bit g,
                       input bit p);
    en = e; A = a; B = b; C = c; G = g; P = p;
  endtask

  // Advance past the next sampling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit x, input bit y, input bit v,
                            input bit e, input int unsigned cnt);
    check({tag, "_X"}, X, x);
    check({tag, "_Y"}, Y, y);
    check({tag, "_valid"}, valid, v);
    check({tag, "_pg_err"}, pg_err, e);
    check({tag, "_cnt"}, carry_cnt, cnt);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    chk_on = 1'b0;
    rst    = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #12;
    expect_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    step();
    expect_out("post_reset", 0, 0, 0, 0, 0);

    // G=1 without A&B: carry from G, pg_err flags it
    drive(1'b1, 1, 0, 1, 1, 0);
    step();
    expect_out("vec2", 1, 0, 1, 1, 1);

    // P=1 with A|B=0
    drive(1'b1, 0, 0, 0, 0, 1);
    step();
    expect_out("vec3", 0, 0, 1, 1, 1);

    // Consistent PG, no carry-in
    drive(1'b1, 1, 0, 0, 0, 1);
    step();
    expect_out("vec4", 0, 1, 1, 0, 1);

    // Hold with changed inputs
    drive(1'b0, 1, 1, 1, 1, 1);
    step();
    expect_out("hold", 0, 1, 0, 0, 1);
    step();
    expect_out("hold2", 0, 1, 0, 0, 1);

    // Carry through propagate
    drive(1'b1, 1, 0, 1, 0, 1);
    step();
    expect_out("prop", 1, 0, 1, 0, 2);

    // Every input combination; model checks each cycle. 20 of 32 give X=1.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, i[4], i[3], i[2], i[1], i[0]);
      step();
    end
    check("sweep_cnt", carry_cnt, 22);

    // Saturation
    drive(1'b1, 1, 1, 0, 1, 1);
    repeat (300) step();
    expect_out("sat", 1, 0, 1, 0, 255);
    drive(1'b0, 0, 0, 0, 0, 0);
    step();
    expect_out("sat_hold", 1, 0, 0, 0, 255);

    // Asynchronous reset between edges
    drive(1'b1, 1, 1, 0, 1, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_out("rst_over_en", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    expect_out("after_rst", 1, 0, 1, 0, 1);
    drive(1'b0, 0, 0, 0, 0, 0);
    repeat (3) step();
    @(negedge clk);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
